// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IM/DM memory port arbiter.
// FSM state and transaction-owner encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    OWNER_IM = 1'b0,
    OWNER_DM = 1'b1
  } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU masters, the arbiter and memory.
// master: arbiter side (drives o_*); slave: environment side (drives i_*).
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE = DATA_WIDTH / 8;

  logic                  i_im_req;
  logic [ADDR_WIDTH-1:0] i_im_addr;
  logic [DATA_WIDTH-1:0] o_im_rdata;
  logic                  o_im_ack;

  logic                  i_dm_req;
  logic                  i_dm_we;
  logic [BE-1:0]         i_dm_be;
  logic [ADDR_WIDTH-1:0] i_dm_addr;
  logic [DATA_WIDTH-1:0] i_dm_wdata;
  logic [DATA_WIDTH-1:0] o_dm_rdata;
  logic                  o_dm_ack;

  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [BE-1:0]         o_mem_be;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  i_mem_ready;
  logic                  i_mem_rvalid;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  modport master (
    input  i_im_req, i_im_addr,
    output o_im_rdata, o_im_ack,
    input  i_dm_req, i_dm_we, i_dm_be,
    input  i_dm_addr, i_dm_wdata,
    output o_dm_rdata, o_dm_ack,
    output o_mem_req, o_mem_we, o_mem_be,
    output o_mem_addr, o_mem_wdata,
    input  i_mem_ready, i_mem_rvalid,
    input  i_mem_rdata
  );

  modport slave (
    output i_im_req, i_im_addr,
    input  o_im_rdata, o_im_ack,
    output i_dm_req, i_dm_we, i_dm_be,
    output i_dm_addr, i_dm_wdata,
    input  o_dm_rdata, o_dm_ack,
    input  o_mem_req, o_mem_we, o_mem_be,
    input  o_mem_addr, o_mem_wdata,
    output i_mem_ready, i_mem_rvalid,
    output i_mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IM) and data (DM).
// Ports: i_clock, i_reset (async, active-high), bus (master modport).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STARVE = 4
) (
  input logic i_clock,
  input logic i_reset,
  mem_port_arbiter_if.master bus
);

  localparam int BE = DATA_WIDTH / 8;
  localparam int SW = $clog2(MAX_STARVE + 1);

  mem_arb_state_t state_q, state_d;
  mem_owner_t     owner_q, owner_d;
  logic [SW-1:0]  starve_q, starve_d;

  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [BE-1:0]         be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [DATA_WIDTH-1:0] im_rdata_q, im_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  im_ack_q, im_ack_d;
  logic                  dm_ack_q, dm_ack_d;

  logic starve_max;
  logic grant_im;
  logic grant_dm;

  assign starve_max = (starve_q == SW'(MAX_STARVE));

  // DM wins ties unless IM has waited through MAX_STARVE DM grants.
  always_comb begin
    grant_im = 1'b0;
    grant_dm = 1'b0;
    unique case ({bus.i_im_req, bus.i_dm_req})
      2'b10: grant_im = 1'b1;
      2'b01: grant_dm = 1'b1;
      2'b11: begin
        if (starve_max) grant_im = 1'b1;
        else            grant_dm = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    im_rdata_d = im_rdata_q;
    dm_rdata_d = dm_rdata_q;
    im_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.i_im_req) starve_d = '0;
        if (grant_im) begin
          state_d  = REQ;
          owner_d  = OWNER_IM;
          starve_d = '0;
          req_d    = 1'b1;
          we_d     = 1'b0;
          be_d     = '1;
          addr_d   = bus.i_im_addr;
          wdata_d  = '0;
        end else if (grant_dm) begin
          state_d = REQ;
          owner_d = OWNER_DM;
          req_d   = 1'b1;
          we_d    = bus.i_dm_we;
          be_d    = bus.i_dm_be;
          addr_d  = bus.i_dm_addr;
          wdata_d = bus.i_dm_wdata;
          // Only DM grants that bypass a waiting IM count.
          if (bus.i_im_req && !starve_max)
            starve_d = starve_q + SW'(1);
        end
      end
      REQ: begin
        if (bus.i_mem_ready) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end
      end
      WAIT: begin
        if (bus.i_mem_rvalid) begin
          state_d = RESP;
          if (owner_q == OWNER_IM) begin
            im_rdata_d = bus.i_mem_rdata;
            im_ack_d   = 1'b1;
          end else begin
            dm_rdata_d = bus.i_mem_rdata;
            dm_ack_d   = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_IM;
      starve_q   <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
      im_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      im_rdata_q <= im_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      im_ack_q   <= im_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

  assign bus.o_mem_req   = req_q;
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_be    = be_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_im_rdata  = im_rdata_q;
  assign bus.o_im_ack    = im_ack_q;
  assign bus.o_dm_rdata  = dm_rdata_q;
  assign bus.o_dm_ack    = dm_ack_q;

  // Masters must hold request and command until their ack.
  a_im_hold: assert property (
    @(posedge i_clock) disable iff (i_reset)
    ($past(bus.i_im_req) && !$past(bus.o_im_ack)
      && !$past(i_reset))
    |-> (bus.i_im_req && $stable(bus.i_im_addr))
  );

  a_dm_hold: assert property (
    @(posedge i_clock) disable iff (i_reset)
    ($past(bus.i_dm_req) && !$past(bus.o_dm_ack)
      && !$past(i_reset))
    |-> (bus.i_dm_req && $stable(bus.i_dm_we)
      && $stable(bus.i_dm_be) && $stable(bus.i_dm_addr)
      && $stable(bus.i_dm_wdata))
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction model,
// per-cycle compare and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 4;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STARVE(MS)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // ---------------- master agents ----------------
  logic [31:0] im_q[$];
  dm_cmd_t     dm_q[$];
  int          im_start = 0;
  int          dm_start = 0;
  bit          seen_im_ack = 0;
  bit          seen_dm_ack = 0;

  always @(posedge clk) begin : agents
    dm_cmd_t c;
    #2;
    if (rst) begin
      bus.i_im_req = 1'b0;
      bus.i_dm_req = 1'b0;
    end else begin
      if (seen_im_ack) bus.i_im_req = 1'b0;
      if (seen_dm_ack) bus.i_dm_req = 1'b0;
      if (!bus.i_im_req && im_q.size() > 0) begin
        bus.i_im_addr = im_q.pop_front();
        bus.i_im_req  = 1'b1;
        im_start      = cyc;
      end
      if (!bus.i_dm_req && dm_q.size() > 0) begin
        c = dm_q.pop_front();
        bus.i_dm_we    = c.we;
        bus.i_dm_be    = c.be;
        bus.i_dm_addr  = c.addr;
        bus.i_dm_wdata = c.wdata;
        bus.i_dm_req   = 1'b1;
        dm_start       = cyc;
      end
    end
  end

  // ---------------- memory responder ----------------
  int          ready_dly = 0;
  int          rv_dly = 0;
  logic [31:0] resp_data = '0;
  bit          stray_rv = 0;
  bit          acc_evt = 0;
  int          req_age = 0;
  int          wcnt = 0;
  bit          wait_act = 0;

  always @(posedge clk) begin : responder
    #2;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = stray_rv;
    bus.i_mem_rdata  = stray_rv ? 32'hBAD0_BAD0 : 32'h0;
    if (rst) begin
      req_age  = 0;
      wait_act = 0;
    end else begin
      if (acc_evt) begin
        wait_act = 1;
        wcnt     = 0;
      end
      if (bus.o_mem_req) begin
        if (req_age >= ready_dly) bus.i_mem_ready = 1'b1;
        req_age++;
      end else begin
        req_age = 0;
      end
      if (wait_act) begin
        if (wcnt == rv_dly) begin
          bus.i_mem_rvalid = 1'b1;
          bus.i_mem_rdata  = resp_data;
          wait_act         = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ---------------- model + per-cycle compare ----------------
  bit          m_busy = 0, m_acc = 0, m_rsp = 0;
  bit          m_owner_dm = 0;
  int          m_starve = 0;
  logic        m_we = 0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [31:0] m_im_rd = '0, m_dm_rd = '0;

  bit          ack_log[$];
  int          im_ack_cyc = 0, dm_ack_cyc = 0;
  int          req_hi = 0;
  bit          prev_req = 0;
  logic        cap_we = 0;
  logic [3:0]  cap_be = '0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  int          cap_cyc = 0;

  always @(negedge clk) begin : compare
    bit pick_im;
    bit exp_req;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_rsp = 0; m_starve = 0;
      m_im_rd = '0; m_dm_rd = '0;
      chk("rst_mem_we", bus.o_mem_we, 0);
      chk("rst_mem_be", bus.o_mem_be, 0);
      chk("rst_mem_addr", bus.o_mem_addr, 0);
      chk("rst_mem_wdata", bus.o_mem_wdata, 0);
    end
    exp_req = m_busy && !m_acc;
    chk("mem_req", bus.o_mem_req, exp_req);
    if (exp_req) begin
      chk("mem_we", bus.o_mem_we, m_we);
      chk("mem_be", bus.o_mem_be, m_be);
      chk("mem_addr", bus.o_mem_addr, m_addr);
      chk("mem_wdata", bus.o_mem_wdata, m_wdata);
    end
    chk("im_ack", bus.o_im_ack, m_rsp && !m_owner_dm);
    chk("dm_ack", bus.o_dm_ack, m_rsp && m_owner_dm);
    chk("im_rdata", bus.o_im_rdata, m_im_rd);
    chk("dm_rdata", bus.o_dm_rdata, m_dm_rd);

    seen_im_ack = bus.o_im_ack;
    seen_dm_ack = bus.o_dm_ack;
    acc_evt     = bus.o_mem_req && bus.i_mem_ready;
    if (bus.o_mem_req && !prev_req) begin
      cap_we = bus.o_mem_we; cap_be = bus.o_mem_be;
      cap_addr = bus.o_mem_addr; cap_wdata = bus.o_mem_wdata;
      cap_cyc = cyc;
    end
    prev_req = bus.o_mem_req;
    if (bus.o_mem_req) req_hi++;
    if (bus.o_im_ack) begin ack_log.push_back(0); im_ack_cyc = cyc; end
    if (bus.o_dm_ack) begin ack_log.push_back(1); dm_ack_cyc = cyc; end

    if (!rst) begin
      if (!m_busy) begin
        if (bus.i_im_req || bus.i_dm_req) begin
          pick_im = bus.i_im_req &&
                    (!bus.i_dm_req || m_starve == MS);
          m_busy = 1; m_acc = 0; m_rsp = 0;
          if (pick_im) begin
            m_owner_dm = 0; m_starve = 0;
            m_we = 0; m_be = 4'hF;
            m_addr = bus.i_im_addr; m_wdata = '0;
          end else begin
            m_owner_dm = 1;
            m_starve = bus.i_im_req ?
                       ((m_starve < MS) ? m_starve + 1 : MS) : 0;
            m_we = bus.i_dm_we; m_be = bus.i_dm_be;
            m_addr = bus.i_dm_addr; m_wdata = bus.i_dm_wdata;
          end
        end else begin
          m_starve = 0;
        end
      end else if (!m_acc) begin
        if (bus.i_mem_ready) m_acc = 1;
      end else if (!m_rsp) begin
        if (bus.i_mem_rvalid) begin
          m_rsp = 1;
          if (m_owner_dm) m_dm_rd = bus.i_mem_rdata;
          else            m_im_rd = bus.i_mem_rdata;
        end
      end else begin
        m_busy = 0; m_acc = 0; m_rsp = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(string name, int budget);
    int n = 0;
    while ((im_q.size() > 0 || dm_q.size() > 0 ||
            bus.i_im_req || bus.i_dm_req || m_busy) &&
           n < budget) begin
      step(1);
      n++;
    end
    chk({"timeout_", name}, n < budget, 1);
    step(1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int base;
    int r0;
    bit exp5 [12];
    dm_cmd_t c;

    bus.i_im_req = 0; bus.i_im_addr = '0;
    bus.i_dm_req = 0; bus.i_dm_we = 0; bus.i_dm_be = '0;
    bus.i_dm_addr = '0; bus.i_dm_wdata = '0;
    bus.i_mem_ready = 0; bus.i_mem_rvalid = 0;
    bus.i_mem_rdata = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", bus.o_mem_req, 0);
    chk("reset_im_ack", bus.o_im_ack, 0);
    chk("reset_dm_ack", bus.o_dm_ack, 0);
    chk("reset_im_rdata", bus.o_im_rdata, 0);
    step(1);
    rst = 1'b0;
    step(2);

    // IM read, immediate memory
    base = ack_log.size();
    r0 = req_hi;
    resp_data = 32'hDEAD_BEEF;
    im_q.push_back(32'h100);
    wait_quiet("im_read", 50);
    chk("t2_req_latency", cap_cyc - im_start, 1);
    chk("t2_we", cap_we, 0);
    chk("t2_be", cap_be, 4'hF);
    chk("t2_addr", cap_addr, 32'h100);
    chk("t2_wdata", cap_wdata, 0);
    chk("t2_ack_latency", im_ack_cyc - im_start, 3);
    chk("t2_ack_count", ack_log.size() - base, 1);
    chk("t2_im_rdata", bus.o_im_rdata, 32'hDEAD_BEEF);
    chk("t2_req_cycles", req_hi - r0, 1);

    // DM write
    base = ack_log.size();
    resp_data = 32'h55AA_0000;
    c = '{we: 1'b1, be: 4'h3, addr: 32'h2004, wdata: 32'h1234};
    dm_q.push_back(c);
    wait_quiet("dm_write", 50);
    chk("t3_we", cap_we, 1);
    chk("t3_be", cap_be, 4'h3);
    chk("t3_addr", cap_addr, 32'h2004);
    chk("t3_wdata", cap_wdata, 32'h1234);
    chk("t3_ack_count", ack_log.size() - base, 1);
    chk("t3_ack_owner", ack_log[base], 1);
    chk("t3_ack_latency", dm_ack_cyc - dm_start, 3);
    chk("t3_dm_rdata", bus.o_dm_rdata, 32'h55AA_0000);
    chk("t3_im_rdata_kept", bus.o_im_rdata, 32'hDEAD_BEEF);

    // Both pending: DM first, IM right after
    base = ack_log.size();
    resp_data = 32'h0BAD_F00D;
    c = '{we: 1'b0, be: 4'hF, addr: 32'h800, wdata: 32'h0};
    im_q.push_back(32'h400);
    dm_q.push_back(c);
    wait_quiet("both", 60);
    chk("t4_ack_count", ack_log.size() - base, 2);
    chk("t4_first_dm", ack_log[base], 1);
    chk("t4_second_im", ack_log[base+1], 0);
    chk("t4_back_to_back", im_ack_cyc - dm_ack_cyc, 4);

    // Starvation bound
    base = ack_log.size();
    rv_dly = 1;
    resp_data = 32'h7777_1111;
    exp5 = '{1,1,1,1,0,1,1,1,1,0,1,1};
    for (int i = 0; i < 10; i++) begin
      c.we = i[0]; c.be = 4'hF;
      c.addr = 32'h3000 + 32'(4 * i);
      c.wdata = 32'(i * 32'h11);
      dm_q.push_back(c);
    end
    im_q.push_back(32'h500);
    im_q.push_back(32'h504);
    wait_quiet("starve", 300);
    chk("t5_ack_count", ack_log.size() - base, 12);
    for (int i = 0; i < 12; i++) begin
      if (base + i < ack_log.size())
        chk($sformatf("t5_order_%0d", i), ack_log[base+i], exp5[i]);
    end
    chk("t5_dm_rdata", bus.o_dm_rdata, 32'h7777_1111);

    // Slow ready, stray rvalid while in REQ
    base = ack_log.size();
    r0 = req_hi;
    rv_dly = 0;
    ready_dly = 5;
    resp_data = 32'hCAFE_F00D;
    im_q.push_back(32'h600);
    step(2);
    stray_rv = 1;
    step(3);
    stray_rv = 0;
    wait_quiet("slow_ready", 60);
    chk("t6_req_cycles", req_hi - r0, 6);
    chk("t6_ack_count", ack_log.size() - base, 1);
    chk("t6_ack_latency", im_ack_cyc - im_start, 8);
    chk("t6_im_rdata", bus.o_im_rdata, 32'hCAFE_F00D);
    chk("t6_addr", cap_addr, 32'h600);

    // Reset mid-WAIT, late rvalid ignored
    base = ack_log.size();
    ready_dly = 0;
    rv_dly = 4;
    resp_data = 32'h1357_2468;
    im_q.push_back(32'h700);
    step(3);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_mem_req", bus.o_mem_req, 0);
    chk("t1_mem_addr", bus.o_mem_addr, 0);
    chk("t1_im_rdata", bus.o_im_rdata, 0);
    chk("t1_dm_rdata", bus.o_dm_rdata, 0);
    step(1);
    rst = 1'b0;
    stray_rv = 1;
    step(3);
    stray_rv = 0;
    step(3);
    chk("t1_no_ack", ack_log.size() - base, 0);
    chk("t1_im_rdata_after", bus.o_im_rdata, 0);
    chk("t1_mem_req_after", bus.o_mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
